// File: rtl/carrega_matrizes.sv
// carrega_matrizes: matrix fetch stage. On an accepted start it reads two
// 5x5 matrices of 9-bit words (A at base_a, B at base_b) from the shared RAM
// read port. The words are unpacked into two flat banks, and pronto pulses once
// both banks are complete. The block never writes the RAM.
//
// Parameters: RD_LAT   RAM read latency (1 or 2)
// Ports:      clk, reset (async, active-high)
//             start, base_a, base_b    load request and matrix base addresses
//             endereco, dado_ram       RAM read address / read data
//             matriz_a, matriz_b       row-major banks, element i at [9i+8:9i]
//             ocupado, pronto          load in progress / load complete pulse
//             soma                     sum of all 50 captured words; present only
//                                      when CARREGA_CHECKSUM_EN is defined
module carrega_matrizes #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   base_a,
  input  logic [7:0]   base_b,
  output logic [7:0]   endereco,
  input  logic [8:0]   dado_ram,
  output logic [224:0] matriz_a,
  output logic [224:0] matriz_b,
  output logic         ocupado,
  output logic         pronto
`ifdef CARREGA_CHECKSUM_EN
  ,
  output logic [14:0]  soma
`endif
);

  localparam int unsigned W_DADO  = 9;
  localparam int unsigned W_END   = 8;
  localparam int unsigned W_IDX   = 6;
  localparam int unsigned N_ELEM  = 25;
  localparam int unsigned N_WORDS = 50;

  typedef enum logic [1:0] {OCIOSO, LE_A, LE_B, DRENA} estado_t;

  estado_t            estado;
  logic [W_IDX-1:0]   cont;
  logic [W_END-1:0]   base_a_r;
  logic [W_END-1:0]   base_b_r;
  logic [W_END-1:0]   end_leitura;
  logic               iss_v;
  logic [W_IDX-1:0]   iss_idx;
  logic [RD_LAT-1:0]  pipe_v;
  logic [W_IDX-1:0]   pipe_idx [RD_LAT];
  logic               cap_v;
  logic [W_IDX-1:0]   cap_idx;

  // Address of the word selected by the read-issue counter (8-bit wrap)
  assign end_leitura = (cont < W_IDX'(N_ELEM)) ? base_a_r + W_END'(cont)
                                               : base_b_r + W_END'(cont - W_IDX'(N_ELEM));

  assign cap_v   = pipe_v[RD_LAT-1];
  assign cap_idx = pipe_idx[RD_LAT-1];

  // Control FSM: issues one address per cycle, tags it, waits for the last capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= OCIOSO;
      cont     <= '0;
      base_a_r <= '0;
      base_b_r <= '0;
      endereco <= '0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
      iss_v    <= 1'b0;
      iss_idx  <= '0;
    end else begin
      pronto <= 1'b0;
      iss_v  <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (start) begin
            base_a_r <= base_a;
            base_b_r <= base_b;
            endereco <= base_a;
            cont     <= '0;
            ocupado  <= 1'b1;
            estado   <= LE_A;
          end
        end
        LE_A, LE_B: begin
          // iss_v/iss_idx mark the cycle in which this address is on the bus
          endereco <= end_leitura;
          iss_v    <= 1'b1;
          iss_idx  <= cont;
          cont     <= cont + W_IDX'(1);
          if (cont == W_IDX'(N_ELEM - 1))  estado <= LE_B;
          if (cont == W_IDX'(N_WORDS - 1)) estado <= DRENA;
        end
        DRENA: begin
          if (cap_v && (cap_idx == W_IDX'(N_WORDS - 1))) begin
            ocupado <= 1'b0;
            pronto  <= 1'b1;
            estado  <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  // Tag pipeline: follows each issued address through the RAM latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pipe_idx[i] <= '0;
    end else begin
      pipe_v[0]   <= iss_v;
      pipe_idx[0] <= iss_idx;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Bank write: only the element named by the returning tag is updated
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      matriz_a <= '0;
      matriz_b <= '0;
    end else if (cap_v) begin
      for (int e = 0; e < int'(N_ELEM); e++) begin
        if (cap_idx == W_IDX'(e))
          matriz_a[e*W_DADO +: W_DADO] <= dado_ram;
        if (cap_idx == W_IDX'(e + int'(N_ELEM)))
          matriz_b[e*W_DADO +: W_DADO] <= dado_ram;
      end
    end
  end

`ifdef CARREGA_CHECKSUM_EN
  localparam int unsigned W_SOMA = 15;

  // Running sum of captured words, restarted on each accepted load
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          soma <= '0;
    else if (estado == OCIOSO && start) soma <= '0;
    else if (cap_v)                     soma <= soma + W_SOMA'(dado_ram);
  end
`endif

endmodule

// File: tb/tb_carrega_matrizes.sv
// Bench for carrega_matrizes: two instances (RD_LAT=1 and RD_LAT=2) share the
// same stimulus and RAM contents. A timing/content reference model predicts,
// per cycle, the address, busy, pronto, banks and checksum. A scoreboard holds
// one expected record per accepted load and is drained on every pronto pulse.
module tb_carrega_matrizes;

  typedef struct {
    int           t;
    logic [224:0] a;
    logic [224:0] b;
    int           soma;
  } esperado_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   base_a;
  logic [7:0]   base_b;
  logic [7:0]   end0, end1;
  logic [8:0]   d0, d1, r1;
  logic [224:0] ma0, mb0, ma1, mb1;
  logic         oc0, oc1, pr0, pr1;
  logic [14:0]  s0, s1;

  int tests = 0;
  int fails = 0;
  int edges = 0;

  logic [8:0]   mem [256];
  int           lat [2] = '{1, 2};
  int           acc_t [2];
  logic [224:0] prev_a [2], prev_b [2], new_a [2], new_b [2];
  logic [7:0]   cur_ba [2], cur_bb [2];
  esperado_t    q0 [$];
  esperado_t    q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  // RAM read ports: address sampled at the edge, data after RD_LAT registers
  always @(posedge clk) d0 <= mem[end0];
  always @(posedge clk) begin
    r1 <= mem[end1];
    d1 <= r1;
  end

  carrega_matrizes #(.RD_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .base_a(base_a), .base_b(base_b),
    .endereco(end0), .dado_ram(d0), .matriz_a(ma0), .matriz_b(mb0),
    .ocupado(oc0), .pronto(pr0)
`ifdef CARREGA_CHECKSUM_EN
    , .soma(s0)
`endif
  );

  carrega_matrizes #(.RD_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .start(start), .base_a(base_a), .base_b(base_b),
    .endereco(end1), .dado_ram(d1), .matriz_a(ma1), .matriz_b(mb1),
    .ocupado(oc1), .pronto(pr1)
`ifdef CARREGA_CHECKSUM_EN
    , .soma(s1)
`endif
  );

`ifndef CARREGA_CHECKSUM_EN
  assign s0 = '0;
  assign s1 = '0;
`endif

  task automatic check(input string nome, input logic [224:0] act, input logic [224:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nome, edges, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      acc_t[i]  = -1000;
      prev_a[i] = '0; prev_b[i] = '0;
      new_a[i]  = '0; new_b[i]  = '0;
      cur_ba[i] = '0; cur_bb[i] = '0;
    end
    q0.delete();
    q1.delete();
  endfunction

  // A start sampled at edge t is accepted once the previous pronto edge has passed
  function automatic void model_start(input int t, input logic [7:0] ba, input logic [7:0] bb);
    for (int i = 0; i < 2; i++) begin
      if (t > acc_t[i] + 51 + lat[i]) begin
        esperado_t x;
        x.t = t;
        x.soma = 0;
        for (int k = 0; k < 25; k++) begin
          x.a[9*k +: 9] = mem[8'(int'(ba) + k)];
          x.b[9*k +: 9] = mem[8'(int'(bb) + k)];
          x.soma += int'(x.a[9*k +: 9]) + int'(x.b[9*k +: 9]);
        end
        prev_a[i] = new_a[i];
        prev_b[i] = new_b[i];
        new_a[i]  = x.a;
        new_b[i]  = x.b;
        acc_t[i]  = t;
        cur_ba[i] = ba;
        cur_bb[i] = bb;
        if (i == 0) q0.push_back(x);
        else        q1.push_back(x);
      end
    end
  endfunction

  // Word w of the load lands at edge acc_t + 2 + w + RD_LAT
  function automatic bit capturado(input int i, input int w, input int e);
    return (acc_t[i] + 2 + w + lat[i]) <= e;
  endfunction

  function automatic logic [224:0] exp_bank(input int i, input int e, input bit eh_b);
    logic [224:0] velho, novo, r;
    velho = eh_b ? prev_b[i] : prev_a[i];
    novo  = eh_b ? new_b[i]  : new_a[i];
    for (int k = 0; k < 25; k++)
      r[9*k +: 9] = capturado(i, eh_b ? k + 25 : k, e) ? novo[9*k +: 9] : velho[9*k +: 9];
    return r;
  endfunction

  function automatic int exp_soma(input int i, input int e);
    int s = 0;
    for (int k = 0; k < 25; k++) begin
      if (capturado(i, k, e))      s += int'(new_a[i][9*k +: 9]);
      if (capturado(i, k + 25, e)) s += int'(new_b[i][9*k +: 9]);
    end
    return s;
  endfunction

  // ---------------- per-cycle checker ----------------
  task automatic check_ciclo(input int i, input logic [7:0] ende, input logic [224:0] ma,
                             input logic [224:0] mb, input logic oc, input logic pr,
                             input logic [14:0] so);
    int e = edges;
    int k = e - acc_t[i] - 1;
    string p = $sformatf("L%0d", lat[i]);
    logic [7:0] ea;
    if (k >= -1 && k < 50) begin
      if (k < 25) ea = 8'(int'(cur_ba[i]) + ((k < 0) ? 0 : k));
      else        ea = 8'(int'(cur_bb[i]) + k - 25);
      check({p, " endereco"}, 225'(ende), 225'(ea));
    end
    check({p, " ocupado"}, 225'(oc), 225'((e >= acc_t[i]) && (e <= acc_t[i] + 50 + lat[i])));
    check({p, " pronto"},  225'(pr), 225'(e == acc_t[i] + 51 + lat[i]));
    check({p, " matriz_a"}, ma, exp_bank(i, e, 1'b0));
    check({p, " matriz_b"}, mb, exp_bank(i, e, 1'b1));
`ifdef CARREGA_CHECKSUM_EN
    check({p, " soma"}, 225'(so), 225'(exp_soma(i, e)));
`else
    if (so !== so) $display("unused");
`endif
  endtask

  always @(negedge clk) begin
    check_ciclo(0, end0, ma0, mb0, oc0, pr0, s0);
    check_ciclo(1, end1, ma1, mb1, oc1, pr1, s1);
  end

  // ---------------- scoreboard monitor ----------------
  task automatic sb_check(input int i, input esperado_t x, input logic [224:0] ma,
                          input logic [224:0] mb, input logic [14:0] so);
    string p = $sformatf("L%0d sb", lat[i]);
    check({p, " pronto edge"}, 225'(edges), 225'(x.t + 51 + lat[i]));
    check({p, " A"}, ma, x.a);
    check({p, " B"}, mb, x.b);
`ifdef CARREGA_CHECKSUM_EN
    check({p, " soma"}, 225'(so), 225'(x.soma));
`else
    if (so !== so) $display("unused");
`endif
  endtask

  always @(negedge clk) begin
    if (pr0) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL L1 sb unexpected pronto at edge %0d: got 1 expected 0", edges);
      end else sb_check(0, q0.pop_front(), ma0, mb0, s0);
    end
    if (pr1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL L2 sb unexpected pronto at edge %0d: got 1 expected 0", edges);
      end else sb_check(1, q1.pop_front(), ma1, mb1, s1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ba, input logic [7:0] bb);
    start  = 1'b1;
    base_a = ba;
    base_b = bb;
    model_start(edges + 1, ba, bb);
    step();
    start  = 1'b0;
    base_a = 8'($urandom);
    base_b = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((oc0 || oc1) && n < 200) begin
      step();
      n++;
    end
    check("wait_idle timeout", 225'(n >= 200), 225'(0));
    step();
  endtask

  task automatic wait_pronto0();
    int n = 0;
    while (!pr0 && n < 200) begin
      step();
      n++;
    end
    check("wait_pronto timeout", 225'(n >= 200), 225'(0));
  endtask

  task automatic check_zero();
    check("reset L1 endereco", 225'(end0), '0);
    check("reset L1 banks", ma0 | mb0, '0);
    check("reset L1 flags", 225'({oc0, pr0, s0}), '0);
    check("reset L2 endereco", 225'(end1), '0);
    check("reset L2 banks", ma1 | mb1, '0);
    check("reset L2 flags", 225'({oc1, pr1, s1}), '0);
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    reset  = 1'b1;
    start  = 1'b0;
    base_a = '0;
    base_b = '0;
    for (int a = 0; a < 256; a++) mem[a] = 9'($urandom);
    step();
    step();
    check_zero();
    reset = 1'b0;
    step();

    // Basic load: RAM[i] = i+1
    for (int a = 0; a < 50; a++) mem[a] = 9'(a + 1);
    issue(8'd0, 8'd25);
    wait_idle();
    check("basic L1 A0",  225'(ma0[8:0]),     225'(1));
    check("basic L1 A24", 225'(ma0[224:216]), 225'(25));
    check("basic L1 B0",  225'(mb0[8:0]),     225'(26));
    check("basic L1 B24", 225'(mb0[224:216]), 225'(50));
    check("basic L2 A24", 225'(ma1[224:216]), 225'(25));
    check("basic L2 B24", 225'(mb1[224:216]), 225'(50));
`ifdef CARREGA_CHECKSUM_EN
    check("basic L1 soma", 225'(s0), 225'(1275));
    check("basic L2 soma", 225'(s1), 225'(1275));
`endif

    // Wrap-around: A read from 250..255, 0..18
    for (int i = 0; i < 25; i++) mem[8'(250 + i)] = 9'(i);
    issue(8'd250, 8'd100);
    wait_idle();
    for (int i = 0; i < 25; i += 6)
      check($sformatf("wrap L1 A%0d", i), 225'(ma0[9*i +: 9]), 225'(i));

    // Busy start at cycle 10: ignored, one pronto per instance
    issue(8'($urandom), 8'($urandom));
    repeat (9) step();
    issue(8'($urandom), 8'($urandom));
    wait_idle();

    // Back-to-back: start in the L1 pronto cycle
    issue(8'($urandom), 8'($urandom));
    wait_pronto0();
    issue(8'($urandom), 8'($urandom));
    wait_idle();

    // Randomised loads with random gaps and overlapping regions
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 256; a++) mem[a] = 9'($urandom);
      issue(8'($urandom), 8'($urandom_range(0, 3) == 0 ? 8'(base_a + 8'd3) : 8'($urandom)));
      if (r % 2 == 1) begin
        wait_pronto0();
        issue(8'($urandom), 8'($urandom));
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) step();
    end

    // Reset mid-load aborts; a following load completes normally
    issue(8'($urandom), 8'($urandom));
    repeat (29) step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_zero();
    step();
    reset = 1'b0;
    step();
    for (int a = 0; a < 256; a++) mem[a] = 9'($urandom);
    issue(8'($urandom), 8'($urandom));
    wait_idle();

    check("L1 sb queue drained", 225'(q0.size()), 225'(0));
    check("L2 sb queue drained", 225'(q1.size()), 225'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carrega_matrizes.md
# carrega_matrizes

Matrix fetch stage sitting directly downstream of the RAM preset logic and `fluxo_ram`. On a `start` pulse it reads two 5x5 matrices of 9-bit words, A and B, from the shared RAM through its read port. It unpacks them into two flat register banks and signals `pronto` when both operand banks are valid for the arithmetic core. It never writes the RAM.

## Interface
- `RD_LAT`, 1: RAM read latency in cycles from address to valid `dado_ram`; legal values 1 or 2.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: request a load; sampled only in OCIOSO.
- `base_a` in 8: RAM address of A[0]; captured when `start` is accepted.
- `base_b` in 8: RAM address of B[0]; captured when `start` is accepted.
- `endereco` out 8: RAM read address.
- `dado_ram` in 9: RAM read data.
- `matriz_a` out 225: A, row-major; element i occupies bits [9i+8:9i].
- `matriz_b` out 225: B, same packing.
- `ocupado` out 1: high while a load is in progress.
- `pronto` out 1: one-cycle pulse when both banks are complete.
- `soma` out 15: present only with `CARREGA_CHECKSUM_EN`.

## Operation
- FSM states:
  - OCIOSO: if `start`, capture the bases, go to LE_A, and set `endereco`=`base_a`.
  - LE_A: present `base_a`+i for i=0..24, one address per cycle, then go to LE_B.
  - LE_B: present `base_b`+j for j=0..24, then go to DRENA.
  - DRENA: hold for RD_LAT cycles until the last word is captured, then go to OCIOSO and pulse `pronto`.
- Address arithmetic is 8-bit modulo 256: `base_a`=250 reads 250..255, then 0..18.
- A read-issue counter (0..49) drives the addresses. A RD_LAT-deep valid/index shift pipeline tags the returning data, so capture is never inferred from FSM state alone.
- Captured word k goes to A[k] for k<25 and to B[k-25] otherwise. Only the addressed element is written.
- Banks keep their contents until overwritten by the next load; they are not cleared on `start`.
- `start` is ignored while `ocupado`=1, and no queueing occurs. `start` held high re-triggers immediately on return to OCIOSO.
- `reset` asserted mid-load aborts the load. It clears the FSM to OCIOSO and clears the counters, banks, `endereco`, `ocupado`, `pronto` and `soma` to 0.
- `base_a`/`base_b` may change freely after acceptance without effect. Overlapping A/B regions are legal.

## Timing
- Reset values: `endereco`=0, `matriz_a`=0, `matriz_b`=0, `ocupado`=0, `pronto`=0, `soma`=0.
- `start` is sampled at edge T. The word-k address is present during cycle T+1+k, k=0..49.
- Word k is captured at edge T+2+k+RD_LAT.
- `pronto` is high during the single cycle after edge T+51+RD_LAT, which is 52 edges after `start` for RD_LAT=1.
- `ocupado` rises after edge T and falls at the same edge that raises `pronto`.
- `matriz_a`/`matriz_b` are stable and complete whenever `pronto`=1.
- A `start` in the `pronto` cycle is accepted, since the FSM is already in OCIOSO.
- `endereco` holds its last value while in OCIOSO.

## Configuration
- `CARREGA_CHECKSUM_EN` defined:
  - adds output `soma` [14:0], the unsigned sum of all 50 captured words (max 50×511=25550, no overflow).
  - `soma` clears to 0 at `start` acceptance and accumulates per capture.
  - `soma` is final when `pronto`=1.
- Undefined: the `soma` port and accumulator are absent; all other behaviour is identical.

## Test plan
- **Basic load:** with RD_LAT=1, RAM[i]=i+1 for i=0..49, `base_a`=0, `base_b`=25, pulse `start`.
  - Expect `pronto` 52 edges later.
  - Expect A[0]=1, A[24]=25, B[0]=26, B[24]=50.
  - With the macro defined, expect `soma`=1275.
- **Wrap-around:** `base_a`=250 with RAM[250+i mod 256]=i -> A[i]=i, and `endereco` steps 255 -> 0.
- **RD_LAT=2:** run the basic load -> same bank contents, with `pronto` 53 edges after `start`.
- **Busy start:** pulse `start` again at cycle 10 of a load -> ignored; exactly one `pronto`.
- **Back-to-back:** start in the `pronto` cycle with new bases -> second load begins next cycle; the first contents are held until overwritten.
- **Reset mid-load:** assert `reset` at cycle 30 -> all outputs 0 immediately (asynchronous); after release, `start` performs a full load correctly.
